// File: rtl/buf_capture_ctrl.sv
// buf_capture_ctrl
//   Sample buffer sequencer. A start pulse in IDLE arms the controller. It
//   then captures exactly DEPTH din_vld samples into an internal DEPTH x DW
//   array and drains them in order over a dout_vld/dout_rdy handshake.
//   A registered done pulse follows the final accepted entry.
//
//   Configuration macro: BUF_CTRL_CONT_EN
//     defined   : after the final transfer the controller re-enters CAPTURE
//                 and keeps capturing and draining until abort.
//     undefined : single-shot operation. The final transfer returns to IDLE.
//
// Ports
//   clk      in   clock; all state changes on the rising edge
//   rstn     in   asynchronous active-low reset
//   start    in   arm request; honoured only in IDLE
//   abort    in   synchronous abort to IDLE; highest priority
//   din      in   [DW-1:0] sample data
//   din_vld  in   din valid this cycle
//   dout     out  [DW-1:0] buffer entry at the read pointer
//   dout_vld out  dout valid (READ state)
//   dout_rdy in   consumer accepts dout
//   busy     out  high in CAPTURE or READ
//   done     out  one-cycle pulse after the last entry is accepted
//   wr_ptr   out  [AW-1:0] current write index (debug)
module buf_capture_ctrl #(
  parameter  int DW    = 4,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic          dout_rdy,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] wr_ptr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READ    = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            done_q, done_d;
  logic            wr_en;
  logic [DW-1:0]   mem_q [DEPTH];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;

    if (abort) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d  = CAPTURE;
            wr_ptr_d = '0;
          end
        end
        CAPTURE: begin
          if (din_vld) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (wr_ptr_q == LAST_IDX) begin
              state_d  = READ;
              rd_ptr_d = '0;
            end
          end
        end
        READ: begin
          if (dout_rdy) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (rd_ptr_q == LAST_IDX) begin
              done_d = 1'b1;
`ifdef BUF_CTRL_CONT_EN
              state_d  = CAPTURE;
              wr_ptr_d = '0;
`else
              state_d  = IDLE;
`endif
            end
          end
        end
        default: begin
          state_d  = IDLE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      done_q   <= done_d;
    end
  end

  // Buffer contents are kept across abort; only reset clears them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout     = mem_q[rd_ptr_q];
  assign dout_vld = (state_q == READ);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign wr_ptr   = wr_ptr_q;

endmodule

// File: tb/tb_buf_capture_ctrl.sv
// Self-checking bench for buf_capture_ctrl (DW=4, DEPTH=8).
// A fixed vector table covers single-shot operation. Hand-written sequences
// cover abort, reset and the gapped/backpressure cases. Random traffic is
// checked against a queue-based frame model.
module tb_buf_capture_ctrl;

  localparam int DW    = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk;
  logic          rstn;
  logic          start;
  logic          abort;
  logic [DW-1:0] din;
  logic          din_vld;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          dout_rdy;
  logic          busy;
  logic          done;
  logic [AW-1:0] wr_ptr;

  int checks = 0;
  int errors = 0;

  buf_capture_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .abort    (abort),
    .din      (din),
    .din_vld  (din_vld),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .busy     (busy),
    .done     (done),
    .wr_ptr   (wr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. The frame is a queue: samples are pushed while
  // capturing and popped while draining. m_mode: 0 idle, 1 capturing,
  // 2 draining.
  int            m_mode;
  logic [DW-1:0] m_q[$];
  bit            m_done;
`ifdef BUF_CTRL_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void mdl_reset();
    m_mode = 0;
    m_q.delete();
    m_done = 1'b0;
  endfunction

  function automatic void mdl_step(bit s, bit a, logic [DW-1:0] d, bit v, bit r);
    m_done = 1'b0;
    if (a) begin
      m_mode = 0;
      m_q.delete();
    end else if (m_mode == 0) begin
      if (s) begin
        m_mode = 1;
        m_q.delete();
      end
    end else if (m_mode == 1) begin
      if (v) begin
        m_q.push_back(d);
        if (m_q.size() == DEPTH) m_mode = 2;
      end
    end else begin
      if (r) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_done = 1'b1;
          m_mode = CONT ? 1 : 0;
        end
      end
    end
  endfunction

  function automatic void check_model();
    chk("busy", int'(busy), (m_mode != 0) ? 1 : 0);
    chk("dout_vld", int'(dout_vld), (m_mode == 2) ? 1 : 0);
    if (m_mode == 2) chk("dout", int'(dout), int'(m_q[0]));
    chk("done", int'(done), m_done ? 1 : 0);
    chk("wr_ptr", int'(wr_ptr), (m_mode == 1) ? m_q.size() : 0);
  endfunction

  // Drive one cycle's inputs, clock it, and check against the model.
  task automatic cycle(input bit s, input bit a, input logic [DW-1:0] d,
                       input bit v, input bit r);
    start    = s;
    abort    = a;
    din      = d;
    din_vld  = v;
    dout_rdy = r;
    @(posedge clk);
    mdl_step(s, a, d, v, r);
    #1;
    check_model();
  endtask

  typedef struct {
    bit            start;
    bit            abort;
    logic [DW-1:0] din;
    bit            vld;
    bit            rdy;
    bit            e_busy;
    bit            e_vld;
    logic [DW-1:0] e_dout;
    bit            e_done;
    logic [AW-1:0] e_wp;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int            xfers;
    bit            seen;
    logic [DW-1:0] cnt;

    // Single-shot vector table: start, 8 writes of 1..8, 8 accepts,
    // then abort+start in IDLE and one quiet cycle.
    tbl[0] = '{1, 0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 3'd0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{0, 0, 4'(i), 1, 0, 1, (i == 8), 4'd1, 0, 3'(i % 8)};
    for (int k = 0; k < 8; k++) begin
      if (k < 7)
        tbl[9+k] = '{(k == 2), 0, 4'd0, 0, 1, 1, 1, 4'(k + 2), 0, 3'd0};
      else
        tbl[9+k] = '{0, 0, 4'd0, 0, 1, CONT, 0, 4'd0, 1, 3'd0};
    end
    tbl[17] = '{1, 1, 4'd0, 0, 0, 0, 0, 4'd0, 0, 3'd0};
    tbl[18] = '{0, 0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 3'd0};

    start = 0; abort = 0; din = '0; din_vld = 0; dout_rdy = 0;
    rstn = 1'b1;
    #3 rstn = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_dout_vld", int'(dout_vld), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wr_ptr", int'(wr_ptr), 0);
    #2 rstn = 1'b1;
    mdl_reset();
    cycle(0, 0, '0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].start, tbl[i].abort, tbl[i].din, tbl[i].vld, tbl[i].rdy);
      chk("tbl_busy", int'(busy), int'(tbl[i].e_busy));
      chk("tbl_dout_vld", int'(dout_vld), int'(tbl[i].e_vld));
      if (tbl[i].e_vld) chk("tbl_dout", int'(dout), int'(tbl[i].e_dout));
      chk("tbl_done", int'(done), int'(tbl[i].e_done));
      chk("tbl_wr_ptr", int'(wr_ptr), int'(tbl[i].e_wp));
    end

    // Gapped capture with alternating ready.
    cycle(1, 0, '0, 0, 0);
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, cnt, (i % 2 == 1), 0);
      cnt = cnt + 4'd1;
    end
    xfers = 0;
    seen  = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (dout_vld && (c % 2 == 0)) xfers++;
      cycle(0, 0, '0, 0, (c % 2 == 0));
      if (done) seen = 1;
    end
    chk("gap_xfers", xfers, 8);
    chk("gap_done_seen", int'(seen), 1);
    cycle(0, 1, '0, 0, 0);

    // Abort after 3 writes, then a fresh full frame.
    cycle(1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 4'(i + 5), 1, 0);
    cycle(0, 1, 4'd9, 1, 1);
    chk("abort_wr_ptr", int'(wr_ptr), 0);
    chk("abort_busy", int'(busy), 0);
    cycle(0, 0, '0, 1, 1);
    chk("abort_no_done", int'(done), 0);
    cycle(1, 0, '0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 4'($urandom), 1, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, '0, 0, 1);
    cycle(0, 1, '0, 0, 0);

    // Asynchronous reset in the middle of a capture.
    cycle(1, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 4'(i + 1), 1, 0);
    start = 0; abort = 0; din_vld = 0; dout_rdy = 0;
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_wr_ptr", int'(wr_ptr), 0);
    chk("mid_rst_dout", int'(dout), 0);
    chk("mid_rst_done", int'(done), 0);
    @(negedge clk);
    rstn = 1'b1;
    mdl_reset();
    cycle(0, 0, '0, 0, 0);

`ifdef BUF_CTRL_CONT_EN
    begin
      int dn;
      bit dropped;
      dn = 0;
      dropped = 0;
      cycle(1, 0, '0, 0, 0);
      for (int f = 0; f < 2; f++) begin
        for (int i = 0; i < 8; i++) begin
          cycle(0, 0, 4'(f * 8 + i), 1, 0);
          if (!busy) dropped = 1;
        end
        for (int i = 0; i < 8; i++) begin
          cycle(0, 0, '0, 0, 1);
          if (done) dn++;
          if (!busy) dropped = 1;
        end
      end
      chk("cont_done_pulses", dn, 2);
      chk("cont_busy_drop", int'(dropped), 0);
      cycle(0, 1, '0, 0, 0);
    end
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0),
            4'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buf_capture_ctrl.md
# buf_capture_ctrl

Sequencer for the sample buffer: arms on a start pulse, captures exactly DEPTH consecutive valid samples from the free-running counter path into an internal DEPTH x DW register array, then drains them in order over a valid/ready output handshake. It replaces ad-hoc loop-driven buffer filling in the testbench datapath with a synthesizable, cycle-defined controller sitting between the sample source and any downstream consumer.

## Interface
- DW, 4, sample width in bits
- DEPTH, 8, buffer entries; power of two, >= 2
- AW, $clog2(DEPTH), pointer width (derived, not overridden)
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  arm request; honoured only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- din  in  DW  sample data
- din_vld  in  1  din valid this cycle
- dout  out  DW  buffer entry at read pointer
- dout_vld  out  1  dout valid (READ state)
- dout_rdy  in  1  consumer accepts dout
- busy  out  1  high in CAPTURE or READ
- done  out  1  one-cycle pulse after last entry accepted
- wr_ptr  out  AW  current write index (debug)

## Operation
- States: IDLE, CAPTURE, READ; 2-bit encoded, reset to IDLE.
- IDLE: start=1 -> CAPTURE, wr_ptr<=0. din_vld ignored.
- CAPTURE: on din_vld, buf[wr_ptr]<=din, wr_ptr<=wr_ptr+1 (mod DEPTH). Write with wr_ptr==DEPTH-1 -> READ, rd_ptr<=0. Cycles without din_vld hold state; no timeout.
- READ: dout=buf[rd_ptr] (combinational from array), dout_vld=1. On dout_vld&&dout_rdy rd_ptr<=rd_ptr+1; transfer at rd_ptr==DEPTH-1 -> IDLE (or CAPTURE, see Configuration) and done=1 next cycle.
- abort: highest priority in every state; next state IDLE, pointers 0, buffer contents retained, done not pulsed. abort in IDLE with start: abort wins, stays IDLE.
- start while busy: ignored, no queuing.
- Pointers wrap naturally at DEPTH (AW bits); never written past DEPTH-1 within one capture.
- Buffer never written outside CAPTURE; read outside READ only via dout (dout_vld=0).

## Timing
- Reset values: state IDLE, wr_ptr 0, rd_ptr 0, buf all 0, dout 0, dout_vld 0, busy 0, done 0.
- start sampled at edge N -> busy=1 after edge N; first capturable din_vld at edge N+1.
- Minimum capture: DEPTH cycles with continuous din_vld; last write edge M -> dout_vld=1 after M, dout=buf[0].
- Minimum drain: DEPTH cycles with dout_rdy held 1; done high for exactly one cycle after final accept edge; busy falls same edge.
- dout_rdy may toggle freely; dout/dout_vld stable while dout_rdy=0.
- rstn assertion mid-capture or mid-read: immediate return to reset values; no partial done.

## Configuration
- BUF_CTRL_CONT_EN defined: after final READ transfer, state goes directly to CAPTURE (wr_ptr 0), busy stays 1, done still pulses; continuous capture/drain until abort. start ignored except from IDLE.
- Undefined: single-shot; final transfer returns to IDLE, new start required.

## Test plan
- Reset: rstn low at t=3ns for 3ns mid-idle -> all outputs 0, state IDLE, buf all 0.
- Single shot: start, din=1..8 with din_vld every cycle, dout_rdy=1 -> dout sequence 1,2,...,8 on consecutive cycles, done one pulse, busy low after.
- Gapped input/backpressure: din_vld every other cycle with din=counter, dout_rdy 1-0-1 pattern -> captured values are only din_vld samples, no dout repeats or skips, 8 transfers total.
- abort during CAPTURE after 3 writes -> IDLE next cycle, wr_ptr 0, no done; following start captures 8 fresh samples.
- start in READ and simultaneous abort+start in IDLE -> both ignored, state unchanged / IDLE.
- BUF_CTRL_CONT_EN: two back-to-back frames 0..7 then 8..15 (4-bit wrap) -> done pulses twice, busy never drops between frames.
